muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit; next-generation companion to the single-cycle datapath ALU.
- Sits beside the ALU in the execute stage of the multi-cycle CPU.
- Owns the HI/LO register pair and computes signed/unsigned MULT and DIV iteratively, one bit per cycle.
- Uses a start/busy/done handshake with the control FSM, and supports flush and direct HI/LO writes.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; legal values are 8 to 64.
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived, not overridden).

Ports:
i_MDU_clk  input  1  clock; all state updates on the rising edge.
i_MDU_rst_n  input  1  asynchronous, active-low reset.
i_MDU_start  input  1  request; sampled on the rising edge.
i_MDU_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6-7 are no-op.
i_MDU_srcA  input  WIDTH  multiplicand/dividend, or write data for MTHI/MTLO.
i_MDU_srcB  input  WIDTH  multiplier/divisor.
i_MDU_flush  input  1  abort any in-flight operation.
o_MDU_hi  output  WIDTH  HI register (product upper half / remainder).
o_MDU_lo  output  WIDTH  LO register (product lower half / quotient).
o_MDU_busy  output  1  operation in progress; a new start is ignored while this is high.
o_MDU_done  output  1  one-cycle pulse; HI/LO hold the new result.

Behaviour:
- Reset (asynchronous, i_MDU_rst_n=0):
  - State=IDLE; hi, lo, busy, done and the counter all go to 0.
  - An in-flight operation is discarded; no done pulse follows.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - Start with op 0-3: latch |A| and |B| (signed ops) or raw A and B (unsigned ops). Record result signs. Counter=0. Go to CALC; busy=1 from the next cycle.
  - Start with op 4 or 5: write srcA into hi (MTHI) or lo (MTLO) at that edge. Stay in IDLE; no busy, no done.
  - Start with op 6 or 7: ignored.
- CALC:
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Exactly WIDTH cycles; when the counter reaches WIDTH-1, go to FIX.
- FIX (1 cycle), sign correction:
  - Signed MULT: negate the 2*WIDTH product if the operand signs differ.
  - Signed DIV: quotient truncates toward zero; negate it if the signs differ. The remainder takes the dividend's sign.
  - Write hi/lo at the end of FIX; go to DONE.
- DONE (1 cycle): done=1, busy=0; return to IDLE. A start in this cycle is accepted as if in IDLE.
- Latency: start accepted at edge E0 -> busy high for WIDTH+1 cycles -> done high in the cycle after edge E0+WIDTH+1. Throughput: one op every WIDTH+2 cycles.
- hi/lo hold their previous values throughout CALC and FIX; they change only in FIX, on MTHI/MTLO, or at reset.
- Divide by zero (DIV or DIVU, B=0): lo=all ones, hi=srcA. Full latency still applies; no exception is raised.
- Signed overflow (DIV, A=minimum negative, B=-1): lo=minimum negative, hi=0.
- Flush:
  - Flush in CALC or FIX: go to IDLE next edge; busy=0, no done, hi/lo unchanged.
  - Flush together with start in IDLE: flush wins and the start is dropped.
  - Flush in DONE: no effect; the result is already committed.
- Start while busy: ignored, with no side effects.
- Product/quotient arithmetic is modulo 2^(2*WIDTH) and 2^WIDTH respectively.

Test Plan:
1. WIDTH=32, MULT A=FFFFFFFD (-3), B=00000005 -> done exactly 34 cycles after the start edge; hi=FFFFFFFF, lo=FFFFFFF1.
2. MULTU A=FFFFFFFF, B=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then DIV A=FFFFFFF9 (-7), B=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
3. DIVU A=7, B=0 -> lo=FFFFFFFF, hi=00000007. DIV A=80000000, B=FFFFFFFF -> lo=80000000, hi=00000000.
4. MTHI A=12345678, then MTLO A=9ABCDEF0 on consecutive cycles -> hi/lo update at each accepting edge; busy and done stay 0. A second start pulsed mid-CALC with different operands is ignored; the result matches the first op.
5. Start DIVU 100/7, flush at cycle 10 -> busy drops the next cycle, no done, hi/lo keep prior values. An immediate new MULTU 6*7 then yields lo=0000002A, hi=0.
6. Reset asserted mid-CALC -> hi=lo=0 and busy=done=0 immediately, with no clock edge required. Repeat test 1 with WIDTH=8: MULT FD*05 -> hi=FF, lo=F1, done 10 cycles after start.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit for the execute stage of the multi-cycle CPU.
//   Owns the HI/LO register pair. MULT/MULTU use shift-add and DIV/DIVU use
//   restoring shift-subtract, one bit per cycle. Signed operations run on
//   magnitudes, and the signs are applied in a single correction cycle (FIX).
//
// Ports
//   i_MDU_clk    : clock, rising edge
//   i_MDU_rst_n  : asynchronous active-low reset
//   i_MDU_start  : request strobe, sampled on the rising edge
//   i_MDU_op     : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   i_MDU_srcA   : multiplicand / dividend / MTHI-MTLO write data
//   i_MDU_srcB   : multiplier / divisor
//   i_MDU_flush  : abort an in-flight operation
//   o_MDU_hi     : HI register (product upper half / remainder)
//   o_MDU_lo     : LO register (product lower half / quotient)
//   o_MDU_busy   : operation in progress; starts are ignored while high
//   o_MDU_done   : one-cycle pulse once HI/LO hold a new result
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_MDU_clk,
    input  logic             i_MDU_rst_n,
    input  logic             i_MDU_start,
    input  logic [2:0]       i_MDU_op,
    input  logic [WIDTH-1:0] i_MDU_srcA,
    input  logic [WIDTH-1:0] i_MDU_srcB,
    input  logic             i_MDU_flush,
    output logic [WIDTH-1:0] o_MDU_hi,
    output logic [WIDTH-1:0] o_MDU_lo,
    output logic             o_MDU_busy,
    output logic             o_MDU_done
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    // Two's-complement magnitude. The most negative value maps to 2^(WIDTH-1),
    // which is still correct when the result is read as unsigned.
    function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v[WIDTH-1] ? -v : v;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] r;
        r = neg ? -v : v;
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        logic [2*WIDTH-1:0] r;
        r = neg ? -v : v;
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;

    // Datapath registers: only meaningful once loaded by an accepted start.
    // Multiply layout: {partial product high, multiplier shifting out}.
    // Divide layout:   {partial remainder, dividend shifting in / quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH:0]   div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;

    assign signed_op = ~i_MDU_op[0];
    assign a_mag     = signed_op ? abs_w(i_MDU_srcA) : i_MDU_srcA;
    assign b_mag     = signed_op ? abs_w(i_MDU_srcB) : i_MDU_srcB;

    // Shift-add step: add the multiplicand when the current multiplier bit is
    // set, then shift the whole accumulator right. The carry lands in the MSB.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: shift left, trial-subtract the divisor, and keep the
    // difference only if it is non-negative. Because the remainder stays below
    // the divisor, bit WIDTH of the trial is a reliable sign bit. A zero
    // divisor naturally yields an all-ones quotient and remainder = dividend.
    assign div_shift = {acc_q, 1'b0};
    assign div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, opnd_q};
    assign div_next  = div_trial[WIDTH] ? div_shift[2*WIDTH-1:0]
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_2w(acc_q, neg_res_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;

        case (state_q)
            // DONE behaves like IDLE for new requests, so back-to-back ops
            // run at one per WIDTH+2 cycles.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (i_MDU_start && !i_MDU_flush) begin
                    if (!i_MDU_op[2]) begin
                        is_div_d   = i_MDU_op[1];
                        neg_res_d  = signed_op & (i_MDU_srcA[WIDTH-1] ^ i_MDU_srcB[WIDTH-1]);
                        neg_rem_d  = signed_op & i_MDU_srcA[WIDTH-1];
                        div_zero_d = (i_MDU_srcB == '0);
                        if (i_MDU_op[1]) begin
                            acc_d  = {{WIDTH{1'b0}}, a_mag};
                            opnd_d = b_mag;
                        end else begin
                            acc_d  = {{WIDTH{1'b0}}, b_mag};
                            opnd_d = a_mag;
                        end
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_CALC;
                    end else if (i_MDU_op == OP_MTHI) begin
                        hi_d = i_MDU_srcA;
                    end else if (i_MDU_op == OP_MTLO) begin
                        lo_d = i_MDU_srcA;
                    end
                end
            end

            S_CALC: begin
                if (i_MDU_flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                if (i_MDU_flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (is_div_q) begin
                        // A signed divide by zero keeps hi = dividend: the
                        // remainder takes the dividend's sign, which restores it.
                        hi_d = neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
                        lo_d = div_zero_q ? '1 : neg_w(acc_q[WIDTH-1:0], neg_res_q);
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_MDU_clk or negedge i_MDU_rst_n) begin
        if (!i_MDU_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_ff @(posedge i_MDU_clk) begin
        acc_q  <= acc_d;
        opnd_q <= opnd_d;
    end

    assign o_MDU_hi   = hi_q;
    assign o_MDU_lo   = lo_q;
    assign o_MDU_busy = busy_q;
    assign o_MDU_done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Bench for muldiv_unit at WIDTH=32 and WIDTH=8, with both instances sharing
//   one clock and one reset. Each op is checked against an arithmetic reference
//   model that applies the HI/LO rules directly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start32, flush32, busy32, done32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start8, flush8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .i_MDU_clk(clk), .i_MDU_rst_n(rst_n), .i_MDU_start(start32), .i_MDU_op(op32),
        .i_MDU_srcA(a32), .i_MDU_srcB(b32), .i_MDU_flush(flush32),
        .o_MDU_hi(hi32), .o_MDU_lo(lo32), .o_MDU_busy(busy32), .o_MDU_done(done32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .i_MDU_clk(clk), .i_MDU_rst_n(rst_n), .i_MDU_start(start8), .i_MDU_op(op8),
        .i_MDU_srcA(a8), .i_MDU_srcB(b8), .i_MDU_flush(flush8),
        .o_MDU_hi(hi8), .o_MDU_lo(lo8), .o_MDU_busy(busy8), .o_MDU_done(done8)
    );

    // Reference model: plain integer arithmetic on the w-bit operands.
    task automatic model(input int w, input logic [2:0] op, input logic [63:0] a_in,
                         input logic [63:0] b_in, output logic [63:0] hi, output logic [63:0] lo);
        logic [63:0]         mask, a, b;
        longint              qa, qb, minneg;
        logic signed [127:0] sa, sb, sp;
        logic [127:0]        p;
        mask   = (64'd1 << w) - 64'd1;
        a      = a_in & mask;
        b      = b_in & mask;
        qa     = $signed(a << (64 - w)) >>> (64 - w);
        qb     = $signed(b << (64 - w)) >>> (64 - w);
        minneg = -(longint'(1) << (w - 1));
        hi = '0;
        lo = '0;
        case (op)
            3'd0: begin
                sa = qa; sb = qb; sp = sa * sb; p = sp;
                hi = p[127:0] >> w;
                hi = hi & mask;
                lo = p[63:0] & mask;
            end
            3'd1: begin
                p  = {64'd0, a} * {64'd0, b};
                hi = (p >> w) & {64'd0, mask};
                lo = p[63:0] & mask;
            end
            3'd2: begin
                if (qb == 0) begin
                    lo = mask; hi = a;
                end else if (qa == minneg && qb == -1) begin
                    lo = a; hi = '0;
                end else begin
                    lo = 64'(qa / qb) & mask;
                    hi = 64'(qa % qb) & mask;
                end
            end
            3'd3: begin
                if (b == 0) begin
                    lo = mask; hi = a;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
            default: begin
                hi = '0; lo = '0;
            end
        endcase
    endtask

    // Called at #1 after an edge. Asserts start for one edge, then waits
    // (bounded) for done. lat counts edges from the start edge to the first
    // sample with done high. Returns in the DONE cycle.
    task automatic run_op(input int w, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] hi, output logic [63:0] lo,
                          output int lat, output bit ok);
        if (w == 32) begin
            start32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0];
        end else begin
            start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end
        @(posedge clk); #1;
        start32 = 1'b0;
        start8  = 1'b0;
        lat = 1;
        while (!(w == 32 ? done32 : done8) && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = (w == 32) ? done32 : done8;
        hi = (w == 32) ? {32'd0, hi32} : {56'd0, hi8};
        lo = (w == 32) ? {32'd0, lo32} : {56'd0, lo8};
    endtask

    task automatic test_reset();
        #2;
        checks++; if (hi32 !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi32); end
        checks++; if (lo32 !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo32); end
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy32); end
        checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done32); end
        checks++; if (hi8 !== 8'd0 || lo8 !== 8'd0) begin failures++; $display("FAIL reset_w8 got=%h/%h exp=0/0", hi8, lo8); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2};
        logic [31:0] as  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] bs  [5] = '{32'd5, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF};
        logic [31:0] ehi [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7, 32'd0};
        logic [31:0] elo [5] = '{32'hFFFFFFF1, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        logic [63:0] hi, lo;
        int lat;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            run_op(32, ops[i], {32'd0, as[i]}, {32'd0, bs[i]}, hi, lo, lat, ok);
            checks++; if (!ok) begin failures++; $display("FAIL vec%0d_timeout got=no_done exp=done", i); end
            checks++; if (lat !== 34) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=34", i, lat); end
            checks++; if (hi[31:0] !== ehi[i]) begin failures++; $display("FAIL vec%0d_hi got=%h exp=%h", i, hi[31:0], ehi[i]); end
            checks++; if (lo[31:0] !== elo[i]) begin failures++; $display("FAIL vec%0d_lo got=%h exp=%h", i, lo[31:0], elo[i]); end
            checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL vec%0d_busy_in_done got=%b exp=0", i, busy32); end
            @(posedge clk); #1;
            checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL vec%0d_done_pulse got=%b exp=0", i, done32); end
        end
    endtask

    task automatic test_mthi_mtlo();
        start32 = 1'b1; op32 = 3'd4; a32 = 32'h12345678; b32 = 32'd0;
        @(posedge clk); #1;
        checks++; if (hi32 !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", hi32); end
        checks++; if (busy32 !== 1'b0 || done32 !== 1'b0) begin failures++; $display("FAIL mthi_ctrl got=%b%b exp=00", busy32, done32); end
        op32 = 3'd5; a32 = 32'h9ABCDEF0;
        @(posedge clk); #1;
        start32 = 1'b0;
        checks++; if (lo32 !== 32'h9ABCDEF0) begin failures++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", lo32); end
        checks++; if (hi32 !== 32'h12345678) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", hi32); end
        checks++; if (busy32 !== 1'b0 || done32 !== 1'b0) begin failures++; $display("FAIL mtlo_ctrl got=%b%b exp=00", busy32, done32); end
        // Codes 6 and 7 leave everything untouched.
        start32 = 1'b1; op32 = 3'd6; a32 = 32'h0;
        @(posedge clk); #1;
        op32 = 3'd7;
        @(posedge clk); #1;
        start32 = 1'b0;
        checks++; if (hi32 !== 32'h12345678 || lo32 !== 32'h9ABCDEF0 || busy32 !== 1'b0)
            begin failures++; $display("FAIL noop_ops got=%h/%h/%b exp=12345678/9abcdef0/0", hi32, lo32, busy32); end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] ehi, elo;
        int lat;
        model(32, 3'd1, 64'h0001_2345, 64'h0006_789A, ehi, elo);
        start32 = 1'b1; op32 = 3'd1; a32 = 32'h0001_2345; b32 = 32'h0006_789A;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 1;
        repeat (5) begin @(posedge clk); #1; lat++; end
        start32 = 1'b1; op32 = 3'd2; a32 = 32'd99; b32 = 32'd3;
        @(posedge clk); #1;
        lat++;
        start32 = 1'b0;
        checks++; if (busy32 !== 1'b1) begin failures++; $display("FAIL busy_ignore_busy got=%b exp=1", busy32); end
        while (!done32 && lat < 300) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 34) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=34", lat); end
        checks++; if (hi32 !== ehi[31:0] || lo32 !== elo[31:0])
            begin failures++; $display("FAIL busy_ignore_result got=%h/%h exp=%h/%h", hi32, lo32, ehi[31:0], elo[31:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [63:0] hi, lo;
        int lat;
        bit ok;
        bit seen_done;
        start32 = 1'b1; op32 = 3'd4; a32 = 32'hCAFEF00D;
        @(posedge clk); #1;
        op32 = 3'd5; a32 = 32'h0BADBEEF;
        @(posedge clk); #1;
        op32 = 3'd3; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0;
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy32); end
        seen_done = 1'b0;
        repeat (40) begin
            if (done32) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%b exp=0", seen_done); end
        checks++; if (hi32 !== 32'hCAFEF00D || lo32 !== 32'h0BADBEEF)
            begin failures++; $display("FAIL flush_hilo_kept got=%h/%h exp=cafef00d/0badbeef", hi32, lo32); end
        run_op(32, 3'd1, 64'd6, 64'd7, hi, lo, lat, ok);
        checks++; if (!ok || lo[31:0] !== 32'h2A || hi[31:0] !== 32'h0)
            begin failures++; $display("FAIL flush_then_multu got=%h/%h ok=%b exp=0/2a", hi[31:0], lo[31:0], ok); end
        // Flush together with start in IDLE drops the start, even for MTHI.
        @(posedge clk); #1;
        start32 = 1'b1; flush32 = 1'b1; op32 = 3'd4; a32 = 32'h55555555;
        @(posedge clk); #1;
        op32 = 3'd0;
        @(posedge clk); #1;
        start32 = 1'b0; flush32 = 1'b0;
        checks++; if (hi32 !== 32'h0 || busy32 !== 1'b0)
            begin failures++; $display("FAIL flush_start_idle got=%h/%b exp=0/0", hi32, busy32); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b, ehi, elo, hi, lo;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            a = {32'd0, $urandom};
            b = {32'd0, $urandom};
            model(32, 3'(i), a, b, ehi, elo);
            run_op(32, 3'(i), a, b, hi, lo, lat, ok);
            checks++; if (!ok || lat !== 34) begin failures++; $display("FAIL b2b%0d_latency got=%0d ok=%b exp=34", i, lat, ok); end
            checks++; if (hi !== ehi || lo !== elo)
                begin failures++; $display("FAIL b2b%0d_result got=%h/%h exp=%h/%h", i, hi, lo, ehi, elo); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [63:0] a, b, ehi, elo, hi, lo;
        logic [2:0]  op;
        int lat, w;
        bit ok;
        for (int i = 0; i < 60; i++) begin
            w  = (i < 40) ? 32 : 8;
            op = 3'($urandom_range(0, 3));
            a  = {32'd0, $urandom};
            b  = {32'd0, $urandom};
            if ($urandom_range(0, 7) == 0) b = 64'd0;
            if ($urandom_range(0, 9) == 0) begin
                a = 64'd1 << (w - 1);
                b = 64'hFFFF_FFFF;
            end
            if (w == 8) begin a = a & 64'hFF; b = b & 64'hFF; end
            model(w, op, a, b, ehi, elo);
            run_op(w, op, a, b, hi, lo, lat, ok);
            checks++; if (!ok || lat !== w + 2)
                begin failures++; $display("FAIL rand%0d_latency w=%0d got=%0d ok=%b exp=%0d", i, w, lat, ok, w + 2); end
            checks++; if (hi !== ehi || lo !== elo)
                begin failures++; $display("FAIL rand%0d_result w=%0d op=%0d a=%h b=%h got=%h/%h exp=%h/%h", i, w, op, a, b, hi, lo, ehi, elo); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc_and_w8();
        logic [63:0] hi, lo;
        int lat;
        bit ok;
        bit seen_done;
        start32 = 1'b1; op32 = 3'd4; a32 = 32'h11112222;
        start8  = 1'b1; op8  = 3'd5; a8  = 8'hA5;
        @(posedge clk); #1;
        op32 = 3'd0; a32 = 32'h00001234; b32 = 32'h00005678;
        op8  = 3'd3; a8  = 8'd200;      b8  = 8'd9;
        @(posedge clk); #1;
        start32 = 1'b0; start8 = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (hi32 !== 32'd0 || lo32 !== 32'd0)
            begin failures++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", hi32, lo32); end
        checks++; if (busy32 !== 1'b0 || done32 !== 1'b0)
            begin failures++; $display("FAIL midreset_ctrl got=%b%b exp=00", busy32, done32); end
        checks++; if (lo8 !== 8'd0 || busy8 !== 1'b0)
            begin failures++; $display("FAIL midreset_w8 got=%h/%b exp=0/0", lo8, busy8); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            if (done32 || done8) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL midreset_no_done got=%b exp=0", seen_done); end
        run_op(8, 3'd0, 64'hFD, 64'h05, hi, lo, lat, ok);
        checks++; if (!ok || lat !== 10) begin failures++; $display("FAIL w8_latency got=%0d ok=%b exp=10", lat, ok); end
        checks++; if (hi[7:0] !== 8'hFF || lo[7:0] !== 8'hF1)
            begin failures++; $display("FAIL w8_mult got=%h/%h exp=ff/f1", hi[7:0], lo[7:0]); end
    endtask

    initial begin
        rst_n   = 1'b0;
        start32 = 1'b0; flush32 = 1'b0; op32 = 3'd0; a32 = '0; b32 = '0;
        start8  = 1'b0; flush8  = 1'b0; op8  = 3'd0; a8  = '0; b8  = '0;
        test_reset();
        test_vectors();
        test_mthi_mtlo();
        test_start_while_busy();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid_calc_and_w8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
